// File: rtl/uart_param_loader_if.sv
// uart_param_loader_if: byte-stream, response and parameter-batch signals of the UART parameter loader
interface uart_param_loader_if #(
    parameter int NUM_WORDS = 7,
    parameter int WORD_W = 32
);
    logic [7:0] rx_byte;
    logic rx_byte_valid;
    logic [7:0] tx_byte;
    logic tx_valid;
    logic tx_ready;
    logic [NUM_WORDS*WORD_W-1:0] params;
    logic batch_valid;
    logic batch_ready;
    modport master (
        input rx_byte, rx_byte_valid, tx_ready, batch_ready,
        output tx_byte, tx_valid, params, batch_valid
    );
    modport slave (
        output rx_byte, rx_byte_valid, tx_ready, batch_ready,
        input tx_byte, tx_valid, params, batch_valid
    );
endinterface

// File: rtl/uart_param_loader.sv
// uart_param_loader: parses sync/payload/XOR-checksum frames into a parameter batch and answers ACK/NAK
module uart_param_loader #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TIMEOUT_US = 1000,
    parameter int NUM_WORDS = 7,
    parameter int WORD_W = 32,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input logic clk,
    input logic rst_n,
    uart_param_loader_if.master bus,
    output logic busy,
    output logic err_csum,
    output logic err_timeout,
    output logic err_overrun
);
    localparam int BPW = WORD_W / 8;
    localparam int NB = NUM_WORDS * BPW;
    localparam int CW = $clog2(NB + 1);
    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {HUNT, PAYLOAD, CSUM} state_t;
    state_t state, state_nx;
    logic [CW-1:0] byte_cnt;
    logic [7:0] csum;
    logic [TW-1:0] tmo_cnt;
    logic [7:0] stage [NB];
    logic [NUM_WORDS*WORD_W-1:0] stage_flat;
    logic tmo, take, fin, good, free, load;
    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        for (genvar b = 0; b < BPW; b++) begin : g_byte
            assign stage_flat[w*WORD_W + (BPW-1-b)*8 +: 8] = stage[w*BPW + b];
        end
    end
    assign busy = state != HUNT;
    always_comb begin
        tmo = state != HUNT && tmo_cnt == TW'(TIMEOUT_CYCLES);
        take = bus.rx_byte_valid && !tmo;
        fin = state == CSUM && take;
        good = bus.rx_byte == csum;
        free = !bus.batch_valid || bus.batch_ready;
        load = fin && good && free;
        state_nx = tmo ? HUNT :
                   !take ? state :
                   state == HUNT ? (bus.rx_byte == SYNC_BYTE ? PAYLOAD : HUNT) :
                   state == PAYLOAD ? (byte_cnt == CW'(NB-1) ? CSUM : PAYLOAD) : HUNT;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= HUNT;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            csum <= '0;
            tmo_cnt <= '0;
            for (int k = 0; k < NB; k++) stage[k] <= '0;
            bus.params <= '0;
            bus.batch_valid <= 1'b0;
            bus.tx_valid <= 1'b0;
            bus.tx_byte <= 8'h00;
            err_csum <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            tmo_cnt <= (state == HUNT || tmo || bus.rx_byte_valid) ? '0 : tmo_cnt + 1'b1;
            if (state == HUNT) begin
                byte_cnt <= '0;
                csum <= '0;
            end else if (take && state == PAYLOAD) begin
                byte_cnt <= byte_cnt + 1'b1;
                csum <= csum ^ bus.rx_byte;
                for (int k = 0; k < NB; k++) if (byte_cnt == CW'(k)) stage[k] <= bus.rx_byte;
            end
            err_timeout <= tmo;
            err_csum <= fin && !good;
            err_overrun <= fin && good && !free;
            if (load) bus.params <= stage_flat;
            bus.batch_valid <= load || (bus.batch_valid && !bus.batch_ready);
            // a fresh response overwrites any unsent one
            bus.tx_valid <= fin || (bus.tx_valid && !bus.tx_ready);
            if (fin) bus.tx_byte <= load ? 8'h06 : 8'h15;
        end
    end
endmodule
